// File: rtl/mem_arb_defs.sv
// Shared definitions for the unified-memory port arbiter: FSM states and the
// access-size encodings, which the control unit also uses for memOffset.
package mem_arb_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      D_WAIT = 2'd1,
      I_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] SZ_BYTE = 3'b001;
   localparam logic [2:0] SZ_HALF = 3'b010;
   localparam logic [2:0] SZ_WORD = 3'b100;

   function automatic logic size_legal(input logic [2:0] size);
      return (size == SZ_BYTE) || (size == SZ_HALF) || (size == SZ_WORD);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;
   logic              i_stall;

   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [2:0]        d_size;
   logic              d_unsigned;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   logic              d_err;
   logic              d_stall;

   logic              m_en;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [2:0]        m_size;
   logic              m_unsigned;
   logic [DATA_W-1:0] m_rdata;

   modport slave (
      input  i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_size, d_unsigned, m_rdata,
      output i_rdata, i_done, i_stall, d_rdata, d_done, d_err, d_stall,
      output m_en, m_we, m_addr, m_wdata, m_size, m_unsigned
   );

   modport master (
      output i_req, i_addr, d_read, d_write, d_addr, d_wdata, d_size, d_unsigned, m_rdata,
      input  i_rdata, i_done, i_stall, d_rdata, d_done, d_err, d_stall,
      input  m_en, m_we, m_addr, m_wdata, m_size, m_unsigned
   );
endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Memory latency counter: loads MEM_LAT on issue, counts down to zero and
// flags the cycle in which read data is to be captured.
module mem_lat_counter #(
   parameter int MEM_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic tc
);
   localparam int CNT_W = $clog2(MEM_LAT + 1);

   logic [CNT_W-1:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                count <= '0;
      else if (load)          count <= CNT_W'(MEM_LAT);
      else if (count != '0)   count <= count - CNT_W'(1);
   end

   assign tc = (count == CNT_W'(1));
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is data-over-fetch priority.
module mem_port_arbiter
   import mem_arb_defs::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   mem_port_arbiter_if.slave bus
);
   state_t state, next_state;

   logic              d_req, d_elig, i_elig, size_ok, prefer_d;
   logic              grant_d, grant_i, issue, tc;
   logic              i_done_q, d_done_q, d_err_q;
   logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
   logic              m_en_q, m_we_q, m_unsigned_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_wdata_q;
   logic [2:0]        m_size_q;

   // A requester whose done pulse is showing this cycle is still holding its
   // request; it must not be accepted a second time.
   assign d_req   = bus.d_read | bus.d_write;
   assign d_elig  = d_req & ~d_done_q;
   assign i_elig  = bus.i_req & ~i_done_q;
   assign size_ok = size_legal(bus.d_size);

`ifdef MEM_ARB_RR_EN
   logic rr_prefer_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     rr_prefer_d <= 1'b1;
      else if (grant_d | grant_i)  rr_prefer_d <= grant_i;
   end

   assign prefer_d = rr_prefer_d;
`else
   assign prefer_d = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      next_state = state;
      grant_d    = 1'b0;
      grant_i    = 1'b0;
      unique case (state)
         IDLE: begin
            if (d_elig && (!i_elig || prefer_d)) grant_d = 1'b1;
            else if (i_elig)                     grant_i = 1'b1;
            if (grant_d && size_ok) next_state = D_WAIT;
            if (grant_i)            next_state = I_WAIT;
         end
         D_WAIT:  if (tc) next_state = IDLE;
         I_WAIT:  if (tc) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // An illegal-size data grant completes with an error and never reaches memory.
   assign issue = grant_i | (grant_d & size_ok);

   mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
      .clk  (clk),
      .rst  (rst),
      .load (issue),
      .tc   (tc)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_en_q       <= 1'b0;
         m_we_q       <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_size_q     <= '0;
         m_unsigned_q <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         d_err_q      <= 1'b0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         m_en_q   <= issue;
         i_done_q <= (state == I_WAIT) && tc;
         d_done_q <= ((state == D_WAIT) && tc) || (grant_d && !size_ok);
         d_err_q  <= grant_d && !size_ok;
         if (issue) begin
            m_we_q       <= grant_d & bus.d_write;
            m_addr_q     <= grant_d ? bus.d_addr : bus.i_addr;
            m_wdata_q    <= grant_d ? bus.d_wdata : '0;
            m_size_q     <= grant_d ? bus.d_size : SZ_WORD;
            m_unsigned_q <= grant_d & bus.d_unsigned;
         end
         if ((state == I_WAIT) && tc) i_rdata_q <= bus.m_rdata;
         if ((state == D_WAIT) && tc) d_rdata_q <= bus.m_rdata;
      end
   end

   assign bus.m_en       = m_en_q;
   assign bus.m_we       = m_we_q;
   assign bus.m_addr     = m_addr_q;
   assign bus.m_wdata    = m_wdata_q;
   assign bus.m_size     = m_size_q;
   assign bus.m_unsigned = m_unsigned_q;
   assign bus.i_done     = i_done_q;
   assign bus.i_rdata    = i_rdata_q;
   assign bus.d_done     = d_done_q;
   assign bus.d_err      = d_err_q;
   assign bus.d_rdata    = d_rdata_q;
   // Stalls are forced low during reset so every output reads zero.
   assign bus.i_stall    = bus.i_req & ~i_done_q & ~rst;
   assign bus.d_stall    = d_req & ~d_done_q & ~rst;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboarded bench for mem_port_arbiter at MEM_LAT=2; expected
// winners of contested requests follow MEM_ARB_RR_EN when it is defined.
module tb_mem_port_arbiter;
   localparam int LAT = 2;

   typedef struct {
      logic        err;
      logic        chk;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   men_cnt  = 0;
   int   men_base;
   exp_t iq[$];
   exp_t dq[$];
   exp_t mon_e;
   logic d_first;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      return {a[15:0], ~a[15:0]};
   endfunction

   assign bus.m_rdata = mem_fn(bus.m_addr);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic push(input logic is_d, input logic err, input logic chk, input logic [31:0] data);
      exp_t e;
      e.err  = err;
      e.chk  = chk;
      e.data = data;
      if (is_d) dq.push_back(e);
      else      iq.push_back(e);
   endtask

   // Scoreboard: every done pulse must match the oldest expectation of its port.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.m_en) men_cnt++;
         if (bus.d_done) begin
            if (dq.size() == 0) check("d_done_unexpected", 32'(bus.d_done), 32'd0);
            else begin
               mon_e = dq.pop_front();
               check("d_err", 32'(bus.d_err), 32'(mon_e.err));
               if (mon_e.chk) check("d_rdata", bus.d_rdata, mon_e.data);
            end
         end
         if (bus.i_done) begin
            if (iq.size() == 0) check("i_done_unexpected", 32'(bus.i_done), 32'd0);
            else begin
               mon_e = iq.pop_front();
               check("i_rdata", bus.i_rdata, mon_e.data);
            end
         end
      end
   end

   initial begin
      bus.i_req = 1'b0;      bus.i_addr = '0;
      bus.d_read = 1'b0;     bus.d_write = 1'b0;
      bus.d_addr = '0;       bus.d_wdata = '0;
      bus.d_size = 3'b100;   bus.d_unsigned = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      tick(); tick(); mid();
      check("rst_m_en", 32'(bus.m_en), 32'd0);
      check("rst_i_done", 32'(bus.i_done), 32'd0);
      check("rst_d_done", 32'(bus.d_done), 32'd0);
      check("rst_i_stall", 32'(bus.i_stall), 32'd0);
      check("rst_m_addr", bus.m_addr, 32'd0);
      rst = 1'b0;
      tick(); tick();

      // Single fetch
      bus.i_req = 1'b1; bus.i_addr = 32'h100;
      push(1'b0, 1'b0, 1'b1, 32'h0050_0093);
      mid();
      check("f_c0_stall", 32'(bus.i_stall), 32'd1);
      check("f_c0_m_en", 32'(bus.m_en), 32'd0);
      tick(); mid();
      check("f_c1_m_en", 32'(bus.m_en), 32'd1);
      check("f_c1_m_addr", bus.m_addr, 32'h100);
      check("f_c1_m_size", 32'(bus.m_size), 32'd4);
      check("f_c1_m_we", 32'(bus.m_we), 32'd0);
      check("f_c1_stall", 32'(bus.i_stall), 32'd1);
      tick(); mid();
      check("f_c2_m_en", 32'(bus.m_en), 32'd0);
      check("f_c2_i_done", 32'(bus.i_done), 32'd0);
      check("f_c2_stall", 32'(bus.i_stall), 32'd1);
      tick(); mid();
      check("f_c3_i_done", 32'(bus.i_done), 32'd1);
      check("f_c3_i_rdata", bus.i_rdata, 32'h0050_0093);
      check("f_c3_stall", 32'(bus.i_stall), 32'd0);
      tick(); bus.i_req = 1'b0;
      mid();
      check("f_c4_i_done", 32'(bus.i_done), 32'd0);
      tick();

      // Contested fetch + unsigned byte load: data first
      bus.i_req = 1'b1; bus.i_addr = 32'h108;
      bus.d_read = 1'b1; bus.d_addr = 32'h200; bus.d_size = 3'b001; bus.d_unsigned = 1'b1;
      push(1'b1, 1'b0, 1'b1, mem_fn(32'h200));
      push(1'b0, 1'b0, 1'b1, mem_fn(32'h108));
      tick(); mid();
      check("c_c1_m_addr", bus.m_addr, 32'h200);
      check("c_c1_m_size", 32'(bus.m_size), 32'd1);
      check("c_c1_m_uns", 32'(bus.m_unsigned), 32'd1);
      tick(); tick(); mid();
      check("c_c3_d_done", 32'(bus.d_done), 32'd1);
      check("c_c3_i_done", 32'(bus.i_done), 32'd0);
      check("c_c3_i_stall", 32'(bus.i_stall), 32'd1);
      tick(); bus.d_read = 1'b0; bus.d_unsigned = 1'b0;
      mid();
      check("c_c4_m_en", 32'(bus.m_en), 32'd1);
      check("c_c4_m_addr", bus.m_addr, 32'h108);
      check("c_c4_m_uns", 32'(bus.m_unsigned), 32'd0);
      check("c_c4_m_size", 32'(bus.m_size), 32'd4);
      tick(); mid();
      check("c_c5_i_done", 32'(bus.i_done), 32'd0);
      tick(); mid();
      check("c_c6_i_done", 32'(bus.i_done), 32'd1);
      tick(); bus.i_req = 1'b0;
      tick();

      // Word store
      bus.d_write = 1'b1; bus.d_addr = 32'h204; bus.d_wdata = 32'hDEAD_BEEF; bus.d_size = 3'b100;
      push(1'b1, 1'b0, 1'b0, 32'd0);
      mid();
      men_base = men_cnt;
      tick(); mid();
      check("s_c1_m_en", 32'(bus.m_en), 32'd1);
      check("s_c1_m_we", 32'(bus.m_we), 32'd1);
      check("s_c1_m_addr", bus.m_addr, 32'h204);
      check("s_c1_m_wdata", bus.m_wdata, 32'hDEAD_BEEF);
      check("s_c1_m_size", 32'(bus.m_size), 32'd4);
      tick(); tick(); mid();
      check("s_c3_d_done", 32'(bus.d_done), 32'd1);
      tick(); bus.d_write = 1'b0;
      tick(); tick(); mid();
      check("s_m_en_count", 32'(men_cnt - men_base), 32'd1);

      // Illegal size, then a legal half load
      tick();
      bus.d_read = 1'b1; bus.d_addr = 32'h208; bus.d_size = 3'b011;
      push(1'b1, 1'b1, 1'b0, 32'd0);
      mid();
      men_base = men_cnt;
      tick(); mid();
      check("e_c1_d_done", 32'(bus.d_done), 32'd1);
      check("e_c1_d_err", 32'(bus.d_err), 32'd1);
      check("e_c1_m_en", 32'(bus.m_en), 32'd0);
      tick(); bus.d_read = 1'b0;
      mid();
      check("e_c2_d_done", 32'(bus.d_done), 32'd0);
      check("e_m_en_count", 32'(men_cnt - men_base), 32'd0);
      tick();
      bus.d_read = 1'b1; bus.d_addr = 32'h20A; bus.d_size = 3'b010;
      push(1'b1, 1'b0, 1'b1, mem_fn(32'h20A));
      tick(); mid();
      check("e2_c1_m_en", 32'(bus.m_en), 32'd1);
      tick(); tick(); mid();
      check("e2_c3_d_done", 32'(bus.d_done), 32'd1);
      check("e2_c3_d_err", 32'(bus.d_err), 32'd0);
      tick(); bus.d_read = 1'b0;
      tick();

      // Asynchronous reset mid-access
      bus.d_read = 1'b1; bus.d_addr = 32'h300; bus.d_size = 3'b100;
      tick(); mid();
      check("r_c1_m_en", 32'(bus.m_en), 32'd1);
      tick(); #2 rst = 1'b1;
      #1;
      check("r_m_addr", bus.m_addr, 32'd0);
      check("r_m_size", 32'(bus.m_size), 32'd0);
      check("r_d_stall", 32'(bus.d_stall), 32'd0);
      check("r_d_rdata", bus.d_rdata, 32'd0);
      check("r_i_rdata", bus.i_rdata, 32'd0);
      tick(); mid();
      check("r_c3_d_done", 32'(bus.d_done), 32'd0);
      bus.d_read = 1'b0;
      tick(); mid();
      rst = 1'b0;
      tick();
      bus.i_req = 1'b1; bus.i_addr = 32'h10C;
      push(1'b0, 1'b0, 1'b1, mem_fn(32'h10C));
      tick(); mid();
      check("r2_c1_m_en", 32'(bus.m_en), 32'd1);
      tick(); mid();
      check("r2_c2_i_done", 32'(bus.i_done), 32'd0);
      tick(); mid();
      check("r2_c3_i_done", 32'(bus.i_done), 32'd1);
      tick(); bus.i_req = 1'b0;
      tick();

      // Both held: D, I, D, I with one done every 1+LAT cycles
      bus.i_req = 1'b1; bus.i_addr = 32'h110;
      bus.d_read = 1'b1; bus.d_addr = 32'h220; bus.d_size = 3'b100;
      push(1'b1, 1'b0, 1'b1, mem_fn(32'h220));
      push(1'b1, 1'b0, 1'b1, mem_fn(32'h220));
      push(1'b0, 1'b0, 1'b1, mem_fn(32'h110));
      push(1'b0, 1'b0, 1'b1, mem_fn(32'h110));
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (k == 10) bus.d_read = 1'b0;
         mid();
         check($sformatf("alt_c%0d_m_en", k), 32'(bus.m_en), 32'((k % 3) == 1));
         check($sformatf("alt_c%0d_d_done", k), 32'(bus.d_done), 32'((k == 3) || (k == 9)));
         check($sformatf("alt_c%0d_i_done", k), 32'(bus.i_done), 32'((k == 6) || (k == 12)));
      end
      tick(); bus.i_req = 1'b0;
      tick();

      // Contest right after a lone data grant
`ifdef MEM_ARB_RR_EN
      d_first = 1'b0;
`else
      d_first = 1'b1;
`endif
      bus.d_read = 1'b1; bus.d_addr = 32'h240;
      push(1'b1, 1'b0, 1'b1, mem_fn(32'h240));
      tick(); tick(); tick(); mid();
      check("p_lone_d_done", 32'(bus.d_done), 32'd1);
      tick(); bus.d_read = 1'b0;
      tick();
      bus.d_read = 1'b1; bus.d_addr = 32'h244;
      bus.i_req = 1'b1; bus.i_addr = 32'h114;
      if (d_first) begin
         push(1'b1, 1'b0, 1'b1, mem_fn(32'h244));
         push(1'b0, 1'b0, 1'b1, mem_fn(32'h114));
      end else begin
         push(1'b0, 1'b0, 1'b1, mem_fn(32'h114));
         push(1'b1, 1'b0, 1'b1, mem_fn(32'h244));
      end
      tick(); mid();
      check("p_first_addr", bus.m_addr, d_first ? 32'h244 : 32'h114);
      tick(); tick(); mid();
      check("p_first_done", 32'(d_first ? bus.d_done : bus.i_done), 32'd1);
      tick();
      if (d_first) bus.d_read = 1'b0;
      else         bus.i_req = 1'b0;
      mid();
      check("p_second_addr", bus.m_addr, d_first ? 32'h114 : 32'h244);
      tick(); tick(); mid();
      check("p_second_done", 32'(d_first ? bus.i_done : bus.d_done), 32'd1);
      tick(); bus.d_read = 1'b0; bus.i_req = 1'b0;
      tick(); tick(); mid();

      check("iq_drained", 32'(iq.size()), 32'd0);
      check("dq_drained", 32'(dq.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified instruction/data memory between two requesters:
  - the fetch stage (instruction reads);
  - the memory stage (loads/stores), driven by the control unit's memRead/memWrite/memOffset/unsignedFlag.
- Serialises accesses and models a fixed memory latency.
- Returns read data and generates per-requester stall signals, so the pipeline can run on a single memory macro.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, memory data width.
- MEM_LAT, 1, memory read latency in cycles (legal 1..7); 1 = combinational-read memory.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- i_req  in  1  fetch request; held until i_done
- i_addr  in  ADDR_W  fetch address
- i_rdata  out  DATA_W  fetched word, valid while i_done=1
- i_done  out  1  one-cycle completion pulse for fetch
- i_stall  out  1  i_req & ~i_done
- d_read  in  1  load request (memRead)
- d_write  in  1  store request (memWrite)
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_size  in  3  memOffset encoding: 001 byte, 010 half, 100 word
- d_unsigned  in  1  unsignedFlag, forwarded to memory
- d_rdata  out  DATA_W  load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse for data
- d_err  out  1  qualifies d_done; illegal d_size, access not issued
- d_stall  out  1  (d_read|d_write) & ~d_done
- m_en  out  1  memory command strobe, exactly one cycle per access
- m_we  out  1  write enable, valid with m_en
- m_addr  out  ADDR_W  registered command address
- m_wdata  out  DATA_W  registered store data
- m_size  out  3  registered size; fetch always 100
- m_unsigned  out  1  registered; fetch always 0
- m_rdata  in  DATA_W  memory read data

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; latency counter 0; round-robin pointer points to data.
  - Reset is asynchronous and may arrive at any time. An in-flight access is abandoned: no done pulse, and any memory write already strobed is not undone.
- States:
  - IDLE: no access outstanding.
  - D_WAIT: data access outstanding.
  - I_WAIT: fetch access outstanding.
- Acceptance (edge E0, state IDLE):
  - A requester is eligible if its request is asserted and it did not receive done in the current cycle. This prevents re-accepting a request that is advancing.
  - Default arbitration is fixed priority: data before fetch.
  - On accept: m_* are registered from the winning requester, m_en=1 for the cycle after E0, counter loads MEM_LAT, state goes to D_WAIT or I_WAIT.
  - d_read and d_write both high is a store; m_we=1.
- Wait:
  - m_en=0 after its single cycle.
  - Counter decrements each edge.
  - At the edge where counter==1: capture m_rdata into i_rdata/d_rdata, pulse done for one cycle, state returns to IDLE.
- Latency: request asserted in cycle c → done high in cycle c+1+MEM_LAT. For MEM_LAT=1, m_rdata is sampled in the same cycle as m_en.
- Back-to-back accesses:
  - During a done cycle the arbiter is IDLE, so the other requester may be accepted at that cycle's closing edge.
  - Steady state: the two requesters alternate with no bubble.
- Stores:
  - d_done pulses with the same timing as loads.
  - d_rdata holds m_rdata as captured; it is don't-care for stores.
- Illegal size (d_size not in {001, 010, 100}) with a data request:
  - No m_en is issued.
  - d_done=1 and d_err=1 in the cycle after acceptance; state stays IDLE.
- Requester deasserts mid-access: the access completes normally and the done pulse is still generated (requester ignores it).
- Memory address alignment is not checked; d_addr passes through unchanged.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin arbitration. When both requesters are eligible in IDLE, the one not granted last wins; the pointer updates on every grant.
- Undefined: fixed data-over-fetch priority and no pointer register.

Decomposition:
- Shared package/header mem_arb_defs holds:
  - state encodings IDLE=2'd0, D_WAIT=2'd1, I_WAIT=2'd2;
  - size constants SZ_BYTE=3'b001, SZ_HALF=3'b010, SZ_WORD=3'b100.
- The control unit reuses the size constants for memOffset.
- One natural sub-module: mem_lat_counter (load/decrement/terminal-count, width from MEM_LAT).

Test Plan:
- MEM_LAT=2, only i_req=1, i_addr=0x100, m_rdata=0x00500093 → m_en cycle 1 with m_addr=0x100, m_size=100; i_done and i_rdata=0x00500093 in cycle 3; i_stall=1 in cycles 0-2.
- i_req and d_read both asserted in cycle 0, d_addr=0x200, d_size=001, d_unsigned=1:
  - Data granted first; d_done in cycle 3.
  - Fetch accepted at end of cycle 3; i_done in cycle 6.
  - m_unsigned=1 only during the data command.
- Store: d_write=1, d_addr=0x204, d_wdata=0xDEADBEEF, d_size=100, MEM_LAT=1 → m_en=m_we=1 in cycle 1 with those values; d_done in cycle 2; exactly one m_en.
- d_read=1 with d_size=011 → no m_en; d_done=d_err=1 in cycle 1; next legal request is serviced normally.
- rst asserted asynchronously mid-D_WAIT → all outputs 0 immediately, no done pulse; after release, a fetch completes with nominal latency.
- With MEM_ARB_RR_EN, both requests held continuously → grants alternate D, I, D, I, with one done every 1+MEM_LAT cycles. Without the macro, data wins every contested IDLE.
